// File: rtl/fft_frame_loader.sv
// Streaming-to-frame front end for top_fft: collects POINT_FFT complex samples per frame
// into one of two banks and presents the held bank in parallel while the other bank fills.
module fft_frame_loader #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic                                                  s_valid_i,
    output logic                                                  s_ready_o,
    input  logic [1:0][FRAC_BITS:0]                               s_data_i,
    input  logic                                                  s_last_i,
    output logic [(1<<POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0]      frame_o,
    output logic                                                  frame_valid_o,
    input  logic                                                  frame_ready_i,
    output logic                                                  sync_err_o
);

    localparam int POINT_FFT = 1 << POINT_FFT_POW2;
    localparam logic [POINT_FFT_POW2-1:0] LAST_IDX = POINT_FFT_POW2'(POINT_FFT - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_HELD    = 2'd3;

    // Sample storage: read in parallel, so kept as plain registers rather than block RAM.
    logic [1:0][FRAC_BITS:0]       bank_mem_reg [2][POINT_FFT];

    logic [1:0]                    bank_state_reg  [2];
    logic [1:0]                    bank_state_next [2];
    logic                          fill_sel_reg;
    logic                          fill_sel_next;
    logic                          hold_sel;
    logic [POINT_FFT_POW2-1:0]     wr_idx_reg;
    logic [POINT_FFT_POW2-1:0]     wr_idx_next;
    logic                          sync_err_reg;
    logic                          sync_err_next;

    logic                          fill_full;
    logic                          hold_held;
    logic                          accept;
    logic                          at_last_idx;
    logic                          complete;
    logic                          early_last;
    logic                          release_hold;
    logic                          wr_en;

    // The banks always play opposite roles.
    assign hold_sel  = ~fill_sel_reg;
    assign fill_full = (bank_state_reg[fill_sel_reg] == ST_FULL);
    assign hold_held = (bank_state_reg[hold_sel] == ST_HELD);

    assign s_ready_o     = rst_ni & ~fill_full;
    assign frame_valid_o = hold_held;
    assign sync_err_o    = sync_err_reg;

    assign accept       = s_valid_i & s_ready_o;
    assign at_last_idx  = (wr_idx_reg == LAST_IDX);
    assign complete     = accept & at_last_idx;
    assign early_last   = accept & s_last_i & ~at_last_idx;
    assign release_hold = hold_held & frame_ready_i;
    assign wr_en        = accept & ~early_last;

    always_comb begin
        bank_state_next[0] = bank_state_reg[0];
        bank_state_next[1] = bank_state_reg[1];
        fill_sel_next      = fill_sel_reg;
        wr_idx_next        = wr_idx_reg;
        sync_err_next      = early_last | (complete & ~s_last_i);

        if (early_last) begin
            wr_idx_next                   = '0;
            bank_state_next[fill_sel_reg] = ST_EMPTY;
        end else if (accept) begin
            wr_idx_next                   = at_last_idx ? '0 : wr_idx_reg + 1'b1;
            bank_state_next[fill_sel_reg] = ST_FILLING;
        end

        if (complete) begin
            if (!hold_held || release_hold) begin
                bank_state_next[fill_sel_reg] = ST_HELD;
                bank_state_next[hold_sel]     = ST_EMPTY;
                fill_sel_next                 = ~fill_sel_reg;
            end else begin
                bank_state_next[fill_sel_reg] = ST_FULL;
            end
        end else if (release_hold) begin
            if (fill_full) begin
                // Parked frame moves straight into the hold role: no bubble on frame_valid_o.
                bank_state_next[fill_sel_reg] = ST_HELD;
                bank_state_next[hold_sel]     = ST_EMPTY;
                fill_sel_next                 = ~fill_sel_reg;
            end else begin
                bank_state_next[hold_sel]     = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bank_state_reg[0] <= ST_EMPTY;
            bank_state_reg[1] <= ST_EMPTY;
            fill_sel_reg      <= 1'b0;
            wr_idx_reg        <= '0;
            sync_err_reg      <= 1'b0;
        end else begin
            bank_state_reg[0] <= bank_state_next[0];
            bank_state_reg[1] <= bank_state_next[1];
            fill_sel_reg      <= fill_sel_next;
            wr_idx_reg        <= wr_idx_next;
            sync_err_reg      <= sync_err_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < POINT_FFT; n++) begin
                    bank_mem_reg[b][n] <= '0;
                end
            end
        end else if (wr_en) begin
            bank_mem_reg[fill_sel_reg][wr_idx_reg] <= s_data_i;
        end
    end

    for (genvar gi = 0; gi < POINT_FFT; gi++) begin : g_frame
        assign frame_o[gi] = bank_mem_reg[hold_sel][gi];
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomised and directed bench for fft_frame_loader, checked every cycle against a
// queue-based model of frame assembly and delivery.
module tb_fft_frame_loader;

    typedef logic [1:0][15:0]        samp_t;
    typedef logic [15:0][1:0][15:0]  frame_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   s_valid;
    logic   s_ready;
    samp_t  s_data;
    logic   s_last;
    frame_t frame_o;
    logic   frame_valid;
    logic   frame_ready;
    logic   sync_err;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: samples of the frame being assembled, and complete frames awaiting the consumer.
    samp_t  partial[$];
    frame_t frames[$];
    bit     exp_err  = 1'b0;
    bit     last_acc = 1'b0;

    always #5 clk = ~clk;

    fft_frame_loader #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .s_data_i      (s_data),
        .s_last_i      (s_last),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .sync_err_o    (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: a frame is accepted while fewer than two frames are outstanding.
    always @(posedge clk) begin
        bit     acc;
        frame_t f;
        if (!rst_n) begin
            partial.delete();
            frames.delete();
            exp_err  = 1'b0;
            last_acc = 1'b0;
        end else begin
            acc      = s_valid && (frames.size() < 2);
            last_acc = acc;
            exp_err  = 1'b0;
            if (frames.size() > 0 && frame_ready) void'(frames.pop_front());
            if (acc) begin
                if (s_last && partial.size() < 15) begin
                    partial.delete();
                    exp_err = 1'b1;
                end else begin
                    partial.push_back(s_data);
                    if (partial.size() == 16) begin
                        for (int k = 0; k < 16; k++) f[k] = partial[k];
                        frames.push_back(f);
                        partial.delete();
                        exp_err = !s_last;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("s_ready", s_ready, 32'(rst_n && frames.size() < 2));
        check("frame_valid", frame_valid, 32'(frames.size() > 0));
        check("sync_err", sync_err, 32'(exp_err));
        if (frames.size() > 0) check_frame("frame_o", frame_o, frames[0]);
    end

    function automatic samp_t mk(input int re, input int im);
        samp_t s;
        s[0] = re[15:0];
        s[1] = im[15:0];
        return s;
    endfunction

    // Called at negedge+1; returns at negedge+1 after the beat was accepted.
    task automatic send(input samp_t d, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // last_at: -1 = last on every 16th beat, -2 = never, otherwise only on beat last_at.
    task automatic send_seq(input int base, input int cnt, input int last_at);
        bit l;
        for (int k = 0; k < cnt; k++) begin
            if (last_at == -1)      l = (k % 16 == 15);
            else if (last_at == -2) l = 1'b0;
            else                    l = (k == last_at);
            send(mk(base + k, -(base + k)), l);
        end
    endtask

    task automatic pulse_ready();
        frame_ready = 1'b1;
        @(negedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_frame_valid", frame_valid, 32'd0);
        check("rst_sync_err", sync_err, 32'd0);
        check_frame("rst_frame_o", frame_o, '0);
        check("rst_s_ready", s_ready, 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 32'd1);
        #1;

        // T1 DC
        frame_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(mk(16'h4000, 0), k == 15);
        check("t1_valid", frame_valid, 32'd1);
        check("t1_re3", frame_o[3][0], 32'h4000);
        check("t1_im9", frame_o[9][1], 32'h0);
        @(negedge clk);
        #1;
        frame_ready = 1'b0;

        // T2 ordering
        send_seq(0, 16, -1);
        check("t2_re15", frame_o[15][0], 32'h000F);
        check("t2_im15", frame_o[15][1], 32'hFFF1);
        pulse_ready();

        // T3 backpressure
        send_seq(0, 32, -1);
        check("t3_ready_low", s_ready, 32'd0);
        check("t3_held_re0", frame_o[0][0], 32'd0);
        frame_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_kept", frame_valid, 32'd1);
        check("t3_swap_re0", frame_o[0][0], 32'd16);
        check("t3_ready_back", s_ready, 32'd1);
        #1;
        frame_ready = 1'b0;
        send_seq(32, 16, -1);
        pulse_ready();
        pulse_ready();

        // T4 simultaneous release and completion
        send_seq(600, 16, -1);
        send_seq(700, 15, -2);
        frame_ready = 1'b1;
        send(mk(715, -715), 1'b1);
        check("t4_valid", frame_valid, 32'd1);
        check("t4_ready", s_ready, 32'd1);
        check("t4_new_re0", frame_o[0][0], 32'd700);
        frame_ready = 1'b0;
        pulse_ready();

        // T5 early and missing last
        send_seq(100, 6, 5);
        check("t5_early_err", sync_err, 32'd1);
        send_seq(200, 16, -1);
        check("t5_re0", frame_o[0][0], 32'd200);
        check("t5_re15", frame_o[15][0], 32'd215);
        check("t5_no_err", sync_err, 32'd0);
        send_seq(300, 16, -2);
        check("t5_missing_err", sync_err, 32'd1);
        pulse_ready();
        pulse_ready();

        // T6 reset mid-frame
        send_seq(400, 16, -1);
        send_seq(420, 7, -2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_ready_in_rst", s_ready, 32'd0);
        check("t6_valid", frame_valid, 32'd0);
        check_frame("t6_frame_zero", frame_o, '0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", s_ready, 32'd1);
        #1;
        send_seq(500, 16, -1);
        check("t6_fresh_re0", frame_o[0][0], 32'd500);
        check("t6_fresh_re15", frame_o[15][0], 32'd515);
        pulse_ready();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 599) != 0);
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = samp_t'($urandom);
            if (partial.size() == 15) s_last = ($urandom_range(0, 15) != 0);
            else                      s_last = ($urandom_range(0, 31) == 0);
            frame_ready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            #1;
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
